imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes instruction memory: the writer side of the instruction-fetch path. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues word writes into the instruction memory. While a load is in progress it holds the processor core in reset, then releases it so execution starts at PC 0 with the new image. It sits beside the processor top, between a host or debug byte source and the instruction memory's write port.

## Interface
- DEPTH_WORDS, 64: instruction memory capacity in 32-bit words; power of two.
- AW, $clog2(DEPTH_WORDS): word-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- load_req  in  1  level; sampled in IDLE to start a load.
- s_valid  in  1  byte source has data.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_waddr  out  AW  word index being written.
- imem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  reset for the processor core (PC, register file).
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at load completion.
- err  out  1  sticky; header word count exceeded DEPTH_WORDS.
- words_loaded  out  16  words written in the current/last load.

## Operation
- Stream format: byte 0/1 = word count N (16-bit, little-endian), then 4*N bytes; the first byte of each word is bits [7:0].
- FSM states: IDLE, HDR0, HDR1, DATA, FIN.
  - IDLE: load_req=1 -> HDR0; clears err and words_loaded.
  - HDR0: accepting a byte latches N[7:0] -> HDR1.
  - HDR1: accepting a byte latches N[15:8] -> DATA, or -> FIN if N==0.
  - DATA: each accepted byte shifts into the word buffer; a 2-bit byte counter wraps 3->0. The 4th byte triggers a write, and the word counter increments. After word N's write is issued -> FIN.
  - FIN: done=1 for one cycle -> IDLE. load_req still high in IDLE starts a new load. The source deasserts it after done.
- A byte transfer occurs only when s_valid && s_ready. s_ready=1 exactly in HDR0, HDR1, DATA. s_data is ignored otherwise.
- Overflow: if N > DEPTH_WORDS, err is set when HDR1 completes. All 4*N bytes are still consumed so the stream stays aligned. imem_we is suppressed for word indices >= DEPTH_WORDS. words_loaded counts only issued writes.
- imem_waddr = word index, starting at 0; no wrap-around (suppression covers the upper range).
- busy=1 in HDR0, HDR1, DATA, FIN.
- cpu_reset = 1 in reset and in HDR0..FIN. It drops in the first IDLE cycle.

## Timing
- Reset values: s_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, cpu_reset 1, busy 0, done 0, err 0, words_loaded 0. State resets to IDLE.
- IDLE with load_req=1 at edge k: HDR0 and busy/cpu_reset=1 from cycle k+1.
- imem_we, imem_waddr, and imem_wdata are registered. They are valid in the cycle after the edge that accepted the word's 4th byte.
- done asserts in the cycle after the final write strobe (FIN). cpu_reset falls one cycle after done.
- Stalls (s_valid=0) may occur between any bytes with no loss. The byte counter and partial word are held.
- Reset asserted mid-load: immediate return to IDLE with reset values. The partial word is discarded and no write is issued. cpu_reset stays 1 through reset.
- Throughput: 1 byte per cycle sustained; one word write per 4 cycles.

## Structure
- Package imem_loader_pkg: state enum (IDLE, HDR0, HDR1, DATA, FIN) and the header-width constant (16).
- Sub-module: byte_packer (4-byte little-endian shift register with 2-bit counter, word_valid pulse, clear input).
- Top contains the FSM, counters, overflow gating, and output registers.

## Test plan
- Reset then idle: cpu_reset=1 during reset, 0 one cycle after release. s_ready=0 and no writes occur.
- N=2, bytes 13 00 00 00 93 00 10 00 with no stalls -> writes (0, 0x00000013) and (1, 0x00100093). done pulses one cycle after the second write. words_loaded=2, err=0.
- Same stream with s_valid dropped for 3 cycles mid-word -> identical writes, delayed by 3 cycles.
- N=0 (bytes 00 00) -> no imem_we. done pulses the cycle after HDR1 completes.
- DEPTH_WORDS=64 with N=66 -> err=1 after the header. Writes are issued for indices 0..63 only. All 264 data bytes are accepted, words_loaded=64, and done pulses.
- Reset asserted after 6 data bytes -> no write for the partial word. State is IDLE, outputs return to reset values, and a following fresh load of N=1 writes index 0 correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Width of the little-endian word-count header at the head of the stream.
  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// The slave modport is the loader's view; master is the byte source / memory side.
interface imem_loader_if #(
  parameter int AW = 6
);
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  modport slave  (input  s_valid, s_data,
                  output s_ready, imem_we, imem_waddr, imem_wdata);
  modport master (output s_valid, s_data,
                  input  s_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: holds three bytes and combines them with
// the fourth as it is accepted, pulsing o_word_valid for that cycle.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] r_buf;
  logic [1:0]  r_cnt;

  // Shift accepted bytes in from the top so the first byte ends up in [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_accept) begin
      r_buf <= {i_byte, r_buf[23:8]};
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_word       = {i_byte, r_buf};
  assign o_word_valid = i_accept && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes 32-bit words into
// instruction memory and holds the core in reset until the image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_req,
  imem_loader_if.slave        bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [HDR_W-1:0]    words_loaded
);

  localparam logic [HDR_W:0] DEPTH_L = (HDR_W+1)'(DEPTH_WORDS);

  state_t           r_state, w_next;
  logic [7:0]       r_n_lo;
  logic [HDR_W-1:0] r_n, r_widx, r_wl;
  logic             r_we, r_err, r_cpu_reset;
  logic [AW-1:0]    r_waddr;
  logic [31:0]      r_wdata;

  logic             w_ready, w_accept, w_clear;
  logic             w_word_valid, w_last_word, w_in_range;
  logic [31:0]      w_word;
  logic [HDR_W-1:0] w_hdr_n;

  assign w_ready     = (r_state == HDR0) || (r_state == HDR1) || (r_state == DATA);
  assign w_accept    = bus.s_valid && w_ready;
  assign w_hdr_n     = {bus.s_data, r_n_lo};
  assign w_in_range  = {1'b0, r_widx} < DEPTH_L;
  assign w_last_word = w_word_valid && ((r_widx + 16'd1) == r_n);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (reset),
    .i_clear      (w_clear),
    .i_accept     (w_accept && (r_state == DATA)),
    .i_byte       (bus.s_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state; FIN waits out an in-flight final write so done trails the last strobe.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (load_req) w_next = HDR0;
      end
      HDR0: if (w_accept) w_next = HDR1;
      HDR1: if (w_accept) w_next = (w_hdr_n == '0) ? FIN : DATA;
      DATA: if (w_last_word) w_next = FIN;
      FIN:  if (!r_we) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Header capture, word counting, overflow gating and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n_lo      <= '0;
      r_n         <= '0;
      r_widx      <= '0;
      r_wl        <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_cpu_reset <= (w_next != IDLE);
      r_we        <= 1'b0;
      if (r_state == IDLE && load_req) begin
        r_err  <= 1'b0;
        r_wl   <= '0;
        r_widx <= '0;
      end
      if (r_state == HDR0 && w_accept) r_n_lo <= bus.s_data;
      if (r_state == HDR1 && w_accept) begin
        r_n <= w_hdr_n;
        if ({1'b0, w_hdr_n} > DEPTH_L) r_err <= 1'b1;
      end
      // Words past the memory top are still counted to keep the stream aligned,
      // but never reach the write port.
      if (w_word_valid) begin
        r_widx <= r_widx + 16'd1;
        if (w_in_range) begin
          r_we    <= 1'b1;
          r_waddr <= r_widx[AW-1:0];
          r_wdata <= w_word;
          r_wl    <= r_wl + 16'd1;
        end
      end
    end
  end

  assign bus.s_ready    = w_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign cpu_reset      = r_cpu_reset;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == FIN) && !r_we;
  assign err            = r_err;
  assign words_loaded   = r_wl;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed timing sequences, a vector
// table of load sizes, and randomized loads checked against a stream model.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic        cpu_reset, busy, done, err;
  logic [15:0] words_loaded;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc;

  typedef struct {
    int          a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t        got[$];
  logic [7:0] stream[$];

  typedef struct {
    int n;
    int stall_max;
    int exp_wl;
    bit exp_err;
  } vec_t;
  vec_t vt[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor.
  always @(negedge clk) begin
    if (!reset && bus.imem_we) got.push_back('{int'(bus.imem_waddr), bus.imem_wdata, cyc});
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic build_stream(input int n);
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic start_load();
    got.delete();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req  = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    chk("byte_accepted", ok, 1);
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom);
  endtask

  task automatic send_stream(input int stall_max, input int stall_at, input int stall_len,
                             input int count);
    int n;
    n = {stream[1], stream[0]};
    for (int i = 0; i < count; i++) begin
      int k;
      k = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
      if (i == stall_at) k = stall_len;
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
      send_byte(stream[i]);
      if (i == 1) chk("err_after_hdr", err, (n > DEPTH));
    end
  endtask

  task automatic wait_done(output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
        chk("cpu_reset_at_done", cpu_reset, 1);
        chk("busy_at_done", busy, 1);
      end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      @(negedge clk);
      chk("cpu_reset_after_done", cpu_reset, 0);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("s_ready_idle", bus.s_ready, 0);
    end
  endtask

  // Reference: from the raw stream, the first min(N, DEPTH) words are written
  // at consecutive indices, each the little-endian assembly of its 4 bytes.
  task automatic model_check();
    int n, nexp;
    logic [31:0] w;
    n    = {stream[1], stream[0]};
    nexp = (n < DEPTH) ? n : DEPTH;
    chk("n_writes", got.size(), nexp);
    for (int i = 0; i < nexp && i < got.size(); i++) begin
      w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      chk("wr_addr", got[i].a, i);
      chk("wr_data", got[i].d, w);
    end
    chk("words_loaded", words_loaded, nexp);
    chk("err_final", err, (n > DEPTH));
  endtask

  task automatic run_load(input int n, input int stall_max, input int stall_at,
                          input int stall_len, output int dcyc);
    build_stream(n);
    start_load();
    send_stream(stall_max, stall_at, stall_len, stream.size());
    wait_done(dcyc);
    model_check();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_we"}, bus.imem_we, 0);
    chk({tag, "_waddr"}, bus.imem_waddr, 0);
    chk({tag, "_wdata"}, bus.imem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_words"}, words_loaded, 0);
  endtask

  initial begin
    int dcyc;
    logic [7:0] fixed[10];
    fixed = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    reset = 1'b1; load_req = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00;

    // Reset, then idle without a request.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("cpu_reset_before_edge", cpu_reset, 1);
    @(posedge clk); #1;
    chk("cpu_reset_released", cpu_reset, 0);
    bus.s_valid = 1'b1; bus.s_data = 8'hAA;
    repeat (5) @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    chk("idle_no_writes", got.size(), 0);
    chk("idle_s_ready", bus.s_ready, 0);
    chk("idle_busy", busy, 0);

    // N=2, fixed bytes, no stalls: exact write and done timing.
    stream.delete();
    foreach (fixed[i]) stream.push_back(fixed[i]);
    start_load();
    chk("busy_after_req", busy, 1);
    chk("cpu_reset_after_req", cpu_reset, 1);
    send_stream(0, -1, 0, stream.size());
    wait_done(dcyc);
    model_check();
    chk("n2_wdata0", (got.size() > 0) ? got[0].d : 0, 32'h0000_0013);
    chk("n2_wdata1", (got.size() > 1) ? got[1].d : 0, 32'h0010_0093);
    chk("n2_w0_cyc", (got.size() > 0) ? got[0].c - start_cyc : -1, 6);
    chk("n2_w1_cyc", (got.size() > 1) ? got[1].c - start_cyc : -1, 10);
    chk("n2_done_cyc", dcyc - start_cyc, 11);

    // Same stream, 3-cycle stall in the middle of the first word.
    start_load();
    send_stream(0, 4, 3, stream.size());
    wait_done(dcyc);
    model_check();
    chk("stall_w0_cyc", (got.size() > 0) ? got[0].c - start_cyc : -1, 9);
    chk("stall_w1_cyc", (got.size() > 1) ? got[1].c - start_cyc : -1, 13);
    chk("stall_done_cyc", dcyc - start_cyc, 14);

    // N=0: done right after the header.
    run_load(0, 0, -1, 0, dcyc);
    chk("n0_done_cyc", dcyc - start_cyc, 2);

    // Overflow: N=66 into 64 words.
    run_load(66, 0, -1, 0, dcyc);
    chk("ovf_last_addr", (got.size() > 0) ? got[got.size()-1].a : -1, DEPTH - 1);

    // Reset after 6 data bytes of an N=2 load: word 0 lands, partial word 1 does not.
    build_stream(2);
    start_load();
    send_stream(0, -1, 0, 8);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("midrst_hold");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cpu_reset_rel", cpu_reset, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_writes", got.size(), 1);
    run_load(1, 0, -1, 0, dcyc);

    // Table of load sizes and source stall levels.
    vt[0] = '{1, 0, 1, 1'b0};
    vt[1] = '{3, 2, 3, 1'b0};
    vt[2] = '{0, 3, 0, 1'b0};
    vt[3] = '{63, 0, 63, 1'b0};
    vt[4] = '{64, 1, 64, 1'b0};
    vt[5] = '{65, 0, 64, 1'b1};
    vt[6] = '{5, 4, 5, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_load(vt[i].n, vt[i].stall_max, -1, 0, dcyc);
      chk("tbl_words", words_loaded, vt[i].exp_wl);
      chk("tbl_err", err, vt[i].exp_err);
    end

    // Randomized loads.
    for (int i = 0; i < 8; i++) begin
      run_load(int'($urandom_range(70, 0)), int'($urandom_range(3, 0)), -1, 0, dcyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
